// File: rtl/msrv32_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// msrv32_dmem_ctrl
//
// Data-memory controller for the msrv32 core. It takes the execute-stage
// load/store request and runs one transaction on a valid/ready request
// channel plus a valid-only response channel. Store data is replicated
// across byte lanes. Load data is shifted down to bit 0 and then sign- or
// zero-extended. The pipeline is stalled until the transaction completes.
//
// Optional feature: define MSRV32_DMEM_TIMEOUT_EN to abort a transaction
// that spends TIMEOUT_CYCLES in REQ or RESP. The abort reports bus_err_out.
//
// Ports
//   clk_in, reset_n_in       clock, asynchronous active-low reset
//   ld_req_in, st_req_in     load / store request (load wins if both are set)
//   addr_in, wr_data_in      byte address, store data (rs2)
//   load_size_in             00 byte, 01 half, 1x word
//   load_unsigned_in         1 = zero-extend the load, 0 = sign-extend
//   dmem_req_out/_we_out     bus request valid / write enable
//   dmem_addr_out            word-aligned address
//   dmem_wdata_out           lane-replicated store data (0 for loads)
//   dmem_wmask_out           byte enables
//   dmem_ready_in            bus accepts the request
//   dmem_rvalid_in           load response valid
//   dmem_rdata_in            load response data
//   dmem_err_in              bus error (qualified by ready / rvalid)
//   stall_out                hold the pipeline
//   load_valid_out           1-cycle pulse, load_data_out is valid
//   load_data_out            aligned and extended load data
//   misaligned_out           1-cycle pulse, misaligned access
//   bus_err_out              1-cycle pulse, bus error or timeout
// ---------------------------------------------------------------------------
module msrv32_dmem_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        ld_req_in,
  input  logic        st_req_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wr_data_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_wmask_out,
  input  logic        dmem_ready_in,
  input  logic        dmem_rvalid_in,
  input  logic [31:0] dmem_rdata_in,
  input  logic        dmem_err_in,
  output logic        stall_out,
  output logic        load_valid_out,
  output logic [31:0] load_data_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  state_t      state_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic        unsigned_q;
  logic        is_load_q;

`ifdef MSRV32_DMEM_TIMEOUT_EN
  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);
  logic [7:0]  cnt_q;
`endif

  logic        req_any;
  logic        misaligned_c;
  logic [3:0]  mask_c;
  logic [31:0] wdata_c;
  logic [31:0] shifted_c;
  logic [31:0] ext_c;

  assign req_any = ld_req_in | st_req_in;

  // Half accesses need bit 0 clear; word accesses need both low bits clear.
  assign misaligned_c = (load_size_in == 2'b01) ? addr_in[0]
                      : (load_size_in[1]        ? (addr_in[1:0] != 2'b00) : 1'b0);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    mask_c  = 4'b1111;
    wdata_c = wr_data_in;
    case (load_size_in)
      2'b00: begin
        mask_c  = 4'b0001 << addr_in[1:0];
        wdata_c = {4{wr_data_in[7:0]}};
      end
      2'b01: begin
        mask_c  = 4'b0011 << addr_in[1:0];
        wdata_c = {2{wr_data_in[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction uses the lane and size captured in IDLE.
  assign shifted_c = dmem_rdata_in >> {lane_q, 3'b000};

  always_comb begin
    ext_c = shifted_c;
    case (size_q)
      2'b00:   ext_c = unsigned_q ? {24'h0, shifted_c[7:0]}
                                  : {{24{shifted_c[7]}}, shifted_c[7:0]};
      2'b01:   ext_c = unsigned_q ? {16'h0, shifted_c[15:0]}
                                  : {{16{shifted_c[15]}}, shifted_c[15:0]};
      default: ;
    endcase
  end

  // Stall is combinational in IDLE so the request cycle itself is held.
  assign stall_out = (state_q == S_REQ) || (state_q == S_RESP) ||
                     ((state_q == S_IDLE) && req_any);

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q        <= S_IDLE;
      size_q         <= 2'b00;
      lane_q         <= 2'b00;
      unsigned_q     <= 1'b0;
      is_load_q      <= 1'b0;
      dmem_req_out   <= 1'b0;
      dmem_we_out    <= 1'b0;
      dmem_addr_out  <= 32'h0;
      dmem_wdata_out <= 32'h0;
      dmem_wmask_out <= 4'h0;
      load_valid_out <= 1'b0;
      load_data_out  <= 32'h0;
      misaligned_out <= 1'b0;
      bus_err_out    <= 1'b0;
`ifdef MSRV32_DMEM_TIMEOUT_EN
      cnt_q          <= 8'h0;
`endif
    end else begin
      // NOTE: state uses non-blocking assignments; the pulse defaults below are
      // overridden by any later assignment in the same cycle.
      load_valid_out <= 1'b0;
      misaligned_out <= 1'b0;
      bus_err_out    <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (req_any) begin
            is_load_q  <= ld_req_in;
            size_q     <= load_size_in;
            lane_q     <= addr_in[1:0];
            unsigned_q <= load_unsigned_in;
            if (misaligned_c) begin
              misaligned_out <= 1'b1;
              state_q        <= S_DONE;
            end else begin
              dmem_req_out   <= 1'b1;
              dmem_we_out    <= ~ld_req_in;
              dmem_addr_out  <= {addr_in[31:2], 2'b00};
              dmem_wdata_out <= ld_req_in ? 32'h0 : wdata_c;
              dmem_wmask_out <= mask_c;
              state_q        <= S_REQ;
`ifdef MSRV32_DMEM_TIMEOUT_EN
              cnt_q          <= 8'h0;
`endif
            end
          end
        end

        S_REQ: begin
          if (dmem_ready_in) begin
            dmem_req_out <= 1'b0;
            if (is_load_q) begin
              state_q <= S_RESP;
`ifdef MSRV32_DMEM_TIMEOUT_EN
              cnt_q   <= 8'h0;
`endif
            end else begin
              bus_err_out <= dmem_err_in;
              state_q     <= S_DONE;
            end
          end
`ifdef MSRV32_DMEM_TIMEOUT_EN
          else if (cnt_q == TimeoutLimit) begin
            dmem_req_out <= 1'b0;
            bus_err_out  <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end

        S_RESP: begin
          if (dmem_rvalid_in) begin
            load_data_out  <= ext_c;
            load_valid_out <= ~dmem_err_in;
            bus_err_out    <= dmem_err_in;
            state_q        <= S_DONE;
          end
`ifdef MSRV32_DMEM_TIMEOUT_EN
          else if (cnt_q == TimeoutLimit) begin
            bus_err_out <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end

        // One-cycle completion; the still-held request is not looked at here.
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msrv32_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_msrv32_dmem_ctrl
//
// Scoreboard bench for msrv32_dmem_ctrl. A driver issues directed and random
// load/store instructions. For each one it pushes the expected bus request
// and the expected completion pulse into queues, and it checks the stall
// length. A bus responder plays memory with per-transaction delays. Two
// monitors pop and compare whenever the DUT presents a bus handshake or a
// completion pulse.
// ---------------------------------------------------------------------------
module tb_msrv32_dmem_ctrl;

`ifdef MSRV32_DMEM_TIMEOUT_EN
  localparam int TbTimeout = 4;
`else
  localparam int TbTimeout = 255;
`endif

  logic        clk_in = 1'b0;
  logic        reset_n_in = 1'b0;
  logic        ld_req_in = 1'b0, st_req_in = 1'b0;
  logic [31:0] addr_in = '0, wr_data_in = '0;
  logic [1:0]  load_size_in = '0;
  logic        load_unsigned_in = 1'b0;
  logic        dmem_req_out, dmem_we_out;
  logic [31:0] dmem_addr_out, dmem_wdata_out;
  logic [3:0]  dmem_wmask_out;
  logic        dmem_ready_in = 1'b0, dmem_rvalid_in = 1'b0, dmem_err_in = 1'b0;
  logic [31:0] dmem_rdata_in = '0;
  logic        stall_out, load_valid_out, misaligned_out, bus_err_out;
  logic [31:0] load_data_out;

  msrv32_dmem_ctrl #(.TIMEOUT_CYCLES(TbTimeout)) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .ld_req_in(ld_req_in), .st_req_in(st_req_in),
    .addr_in(addr_in), .wr_data_in(wr_data_in),
    .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
    .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
    .dmem_addr_out(dmem_addr_out), .dmem_wdata_out(dmem_wdata_out),
    .dmem_wmask_out(dmem_wmask_out), .dmem_ready_in(dmem_ready_in),
    .dmem_rvalid_in(dmem_rvalid_in), .dmem_rdata_in(dmem_rdata_in),
    .dmem_err_in(dmem_err_in), .stall_out(stall_out),
    .load_valid_out(load_valid_out), .load_data_out(load_data_out),
    .misaligned_out(misaligned_out), .bus_err_out(bus_err_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit          ld, st;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr, wdata, rdata;
    bit          err;
    int          rdy_dly, rv_dly;
  } txn_t;

  typedef struct {
    bit          we;
    logic [31:0] addr, wdata;
    logic [3:0]  mask;
  } bus_exp_t;

  typedef struct {
    bit          lv, mis, berr;
    logic [31:0] data;
  } resp_exp_t;

  txn_t      cfg_q[$];
  bus_exp_t  bus_q[$];
  resp_exp_t resp_q[$];

  int checks   = 0;
  int failures = 0;
  bit bus_auto = 1'b0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_misaligned(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd1) return (addr % 2) != 0;
    if (size >= 2'd2) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input bit uns,
                                             input logic [31:0] addr, input logic [31:0] rdata);
    int unsigned lane = addr % 4;
    longint unsigned v = rdata / (longint'(1) << (8 * lane));
    if (size == 2'd0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v + 64'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v + 64'hFFFF_0000;
    end
    return v[31:0];
  endfunction

  function automatic bus_exp_t model_bus(input txn_t t);
    bus_exp_t b;
    int unsigned lane = t.addr % 4;
    b.we   = !t.ld;
    b.addr = t.addr - lane;
    case (t.size)
      2'd0: begin b.mask = 4'(1 << lane); b.wdata = (t.wdata % 256) * 32'h0101_0101; end
      2'd1: begin b.mask = 4'(3 << lane); b.wdata = (t.wdata % 65536) * 32'h0001_0001; end
      default: begin b.mask = 4'hF; b.wdata = t.wdata; end
    endcase
    if (t.ld) b.wdata = 32'h0;
    return b;
  endfunction

  // ---------------- driver ----------------
  task automatic do_txn(input txn_t t);
    bit mis = model_misaligned(t.size, t.addr);
    bit tmo = !mis && (t.rdy_dly > TbTimeout);
    int exp_stall, n;
    resp_exp_t r;
    ld_req_in = t.ld; st_req_in = t.st; addr_in = t.addr; wr_data_in = t.wdata;
    load_size_in = t.size; load_unsigned_in = t.uns;
    r = '{lv: 0, mis: 0, berr: 0, data: 32'h0};
    if (mis) begin
      r.mis = 1; resp_q.push_back(r);
      exp_stall = 1;
    end else begin
      cfg_q.push_back(t);
      bus_q.push_back(model_bus(t));
      if (tmo) begin
        r.berr = 1; resp_q.push_back(r);
        exp_stall = 1 + TbTimeout + 1;
      end else if (t.ld) begin
        if (t.err) r.berr = 1;
        else begin r.lv = 1; r.data = model_load(t.size, t.uns, t.addr, t.rdata); end
        resp_q.push_back(r);
        exp_stall = 1 + (t.rdy_dly + 1) + (t.rv_dly + 1);
      end else begin
        if (t.err) begin r.berr = 1; resp_q.push_back(r); end
        exp_stall = 1 + (t.rdy_dly + 1);
      end
    end
    n = 0;
    while (n < 1000) begin
      @(negedge clk_in);
      if (!stall_out) break;
      n++;
    end
    check("stall_cycles", 128'(n), 128'(exp_stall));
    if (tmo && bus_q.size() > 0) void'(bus_q.pop_front());
    @(posedge clk_in); #1;
    ld_req_in = 0; st_req_in = 0;
  endtask

  // ---------------- bus responder ----------------
  initial begin
    txn_t c;
    bit aborted;
    forever begin
      @(posedge clk_in); #1;
      if (bus_auto && dmem_req_out && cfg_q.size() > 0) begin
        c = cfg_q.pop_front();
        aborted = 0;
        for (int i = 0; i < c.rdy_dly && !aborted; i++) begin
          // rvalid/err noise while ready is low must be ignored by the DUT.
          dmem_rvalid_in = 1'($urandom_range(0, 1));
          dmem_rdata_in  = $urandom;
          dmem_err_in    = 1'($urandom_range(0, 1));
          @(posedge clk_in); #1;
          if (!dmem_req_out) aborted = 1;
        end
        dmem_rvalid_in = 0;
        if (!aborted) begin
          dmem_ready_in = 1;
          dmem_err_in   = c.ld ? 1'($urandom_range(0, 1)) : c.err;
          @(posedge clk_in); #1;
          dmem_ready_in = 0;
          dmem_err_in   = 0;
          if (c.ld) begin
            for (int i = 0; i < c.rv_dly; i++) begin
              dmem_rdata_in = $urandom;
              @(posedge clk_in); #1;
            end
            dmem_rvalid_in = 1; dmem_rdata_in = c.rdata; dmem_err_in = c.err;
            @(posedge clk_in); #1;
            dmem_rvalid_in = 0; dmem_err_in = 0; dmem_rdata_in = $urandom;
          end
        end else begin
          dmem_err_in = 0;
        end
      end
    end
  end

  // ---------------- monitors ----------------
  initial begin
    bus_exp_t b;
    forever begin
      @(negedge clk_in);
      if (mon_en && dmem_req_out) begin
        if (bus_q.size() == 0) begin
          check("bus_unexpected_req", 128'(dmem_req_out), 128'(0));
        end else begin
          b = bus_q[0];
          check("bus_addr", 128'(dmem_addr_out), 128'(b.addr));
          check("bus_we_mask_wdata", {dmem_we_out, dmem_wmask_out, dmem_wdata_out},
                {b.we, b.mask, b.wdata});
          if (dmem_ready_in) void'(bus_q.pop_front());
        end
      end
    end
  end

  initial begin
    resp_exp_t r;
    forever begin
      @(negedge clk_in);
      if (mon_en && (load_valid_out || misaligned_out || bus_err_out)) begin
        if (resp_q.size() == 0) begin
          check("resp_unexpected_pulse", {load_valid_out, misaligned_out, bus_err_out}, 128'(0));
        end else begin
          r = resp_q.pop_front();
          check("resp_lv_mis_err", {load_valid_out, misaligned_out, bus_err_out},
                {r.lv, r.mis, r.berr});
          if (r.lv) check("load_data", 128'(load_data_out), 128'(r.data));
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  function automatic txn_t mk(input bit ld, input bit st, input logic [1:0] size, input bit uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input bit err,
                              input int rdy, input int rv);
    txn_t t;
    t.ld = ld; t.st = st; t.size = size; t.uns = uns; t.addr = addr; t.wdata = wdata;
    t.rdata = rdata; t.err = err; t.rdy_dly = rdy; t.rv_dly = rv;
    return t;
  endfunction

  initial begin
    txn_t t;
    // Reset state.
    #17;
    check("reset_outputs",
          {dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_wmask_out,
           load_valid_out, load_data_out, misaligned_out, bus_err_out, stall_out}, 128'(0));
    @(negedge clk_in); reset_n_in = 1;

    // Reset while in REQ: request drops with no clock edge.
    @(posedge clk_in); #1;
    ld_req_in = 1; addr_in = 32'h10; load_size_in = 2'd2;
    @(posedge clk_in); #1;
    check("req_rise", 128'(dmem_req_out), 128'(1));
    #2; reset_n_in = 0; ld_req_in = 0;
    #1;
    check("rst_in_req_drop", {dmem_req_out, stall_out}, 128'(0));
    @(negedge clk_in); reset_n_in = 1;

    // Reset while in RESP: state back to IDLE with no clock edge.
    @(posedge clk_in); #1;
    ld_req_in = 1; addr_in = 32'h20; load_size_in = 2'd2;
    @(posedge clk_in); #1;
    dmem_ready_in = 1;
    @(posedge clk_in); #1;
    dmem_ready_in = 0; ld_req_in = 0;
    check("resp_stall", {stall_out, dmem_req_out}, {1'b1, 1'b0});
    #2; reset_n_in = 0;
    #1;
    check("rst_in_resp_idle",
          {dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wmask_out, stall_out}, 128'(0));
    @(negedge clk_in); reset_n_in = 1;

    bus_auto = 1; mon_en = 1;
    @(posedge clk_in); #1;

    // Directed cases.
    do_txn(mk(1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80AABBCC, 0, 0, 0));
    do_txn(mk(1, 0, 2'd1, 1, 32'h202, 32'h0, 32'hF00D1234, 0, 3, 0));
    do_txn(mk(0, 1, 2'd0, 0, 32'h301, 32'h000000A5, 32'h0, 0, 0, 0));
    do_txn(mk(1, 0, 2'd2, 0, 32'h402, 32'h0, 32'h0, 0, 0, 0));
    do_txn(mk(1, 1, 2'd2, 0, 32'h500, 32'h12345678, 32'hCAFEF00D, 0, 1, 2));
    do_txn(mk(0, 1, 2'd1, 0, 32'h603, 32'h1234, 32'h0, 0, 0, 0));
    do_txn(mk(0, 1, 2'd2, 0, 32'h700, 32'hDEADBEEF, 32'h0, 1, 2, 0));
    do_txn(mk(1, 0, 2'd1, 0, 32'h800, 32'h0, 32'h00008001, 1, 0, 1));
    // Long ready stall: waits without the timeout, aborts with it.
    do_txn(mk(0, 1, 2'd2, 0, 32'h900, 32'h55AA55AA, 32'h0, 0, 40, 0));

    // Random traffic.
    for (int i = 0; i < 150; i++) begin
      t.ld      = 1'($urandom_range(0, 1));
      t.st      = t.ld ? 1'($urandom_range(0, 1)) : 1'b1;
      t.size    = 2'($urandom_range(0, 3));
      t.uns     = 1'($urandom_range(0, 1));
      t.addr    = $urandom;
      if ($urandom_range(0, 2) != 0) t.addr[1:0] = (t.size == 2'd0) ? t.addr[1:0] :
                                                   (t.size == 2'd1) ? {t.addr[1], 1'b0} : 2'b00;
      t.wdata   = $urandom;
      t.rdata   = $urandom;
      t.err     = ($urandom_range(0, 7) == 0);
      t.rdy_dly = $urandom_range(0, 3);
      t.rv_dly  = $urandom_range(0, 3);
      do_txn(t);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_in); #1;
      end
    end

    repeat (5) @(posedge clk_in);
    check("bus_queue_drained", 128'(bus_q.size()), 128'(0));
    check("resp_queue_drained", 128'(resp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
